window_buffer: RTL and testbench

- Parametrised sliding-window line buffer; successor to the fixed 7-line, 7x7 edge-detect buffer.
- Accepts a raster pixel stream, one pixel per clken beat.
- Presents a P_WIN x P_WIN window of the most recent rows and columns to downstream edge and filter kernels.
- Adds frame tracking, an output valid flag, and selectable border handling (interior-only or zero-pad).

---
 rtl/window_buffer_if.sv | 27 ++
 rtl/window_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_window_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_buffer_if.sv
// Pixel-stream bus for the sliding-window line buffer: raster input beats in,
// packed window, position and delayed pixel out.
interface window_buffer_if #(
    parameter int P_BIT_WIDTH = 24,
    parameter int P_WIN       = 7,
    parameter int P_COL_BITS  = 10
);
    logic                               clken;
    logic                               iSof;
    logic                               iMode;
    logic [P_BIT_WIDTH-1:0]             shiftin;
    logic [P_BIT_WIDTH*P_WIN*P_WIN-1:0] oGrid;
    logic                               oValid;
    logic [P_COL_BITS-1:0]              oRow;
    logic [P_COL_BITS-1:0]              oCol;
    logic [P_BIT_WIDTH-1:0]             shiftout;

    modport master (
        output clken, iSof, iMode, shiftin,
        input  oGrid, oValid, oRow, oCol, shiftout
    );

    modport slave (
        input  clken, iSof, iMode, shiftin,
        output oGrid, oValid, oRow, oCol, shiftout
    );
endinterface

// File: rtl/window_buffer.sv
// Parametrised sliding-window line buffer. P_WIN-1 circular line memories
// feed a P_WIN x P_WIN register window; frame position is tracked so that
// windows are qualified (interior-only) or border-masked (zero-pad).
module window_buffer #(
    parameter int P_BIT_WIDTH  = 24,
    parameter int P_WIN        = 7,
    parameter int P_LINE_WIDTH = 640,
    parameter int P_COL_BITS   = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    window_buffer_if.slave bus
);
    localparam int LP_CELLS  = P_WIN * P_WIN;
    localparam int LP_GRID_W = P_BIT_WIDTH * LP_CELLS;
    localparam logic [P_COL_BITS-1:0] LP_COL_LAST = P_COL_BITS'(P_LINE_WIDTH - 1);
    localparam logic [P_COL_BITS-1:0] LP_EDGE     = P_COL_BITS'(P_WIN - 1);
    localparam logic [P_COL_BITS-1:0] LP_ROW_MAX  = {P_COL_BITS{1'b1}};
    localparam logic [P_COL_BITS-1:0] LP_ONE      = P_COL_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [P_COL_BITS-1:0]   row_q, row_d, col_q, col_d;
    logic                    mode_q, mode_d;
    logic [P_COL_BITS-1:0]   row_cur_s, col_cur_s;
    logic                    mode_cur_s;
    logic                    accept_s;
    logic                    valid_d;

    logic [P_BIT_WIDTH-1:0]  mem_q [P_WIN-1][P_LINE_WIDTH];
    logic [P_BIT_WIDTH-1:0]  line_rd_s [P_WIN-1];
    logic [P_BIT_WIDTH-1:0]  win_q [P_WIN][P_WIN];
    logic [P_BIT_WIDTH-1:0]  win_d [P_WIN][P_WIN];
    logic [LP_GRID_W-1:0]    grid_d;

    logic [LP_GRID_W-1:0]    grid_q;
    logic                    valid_q;
    logic [P_COL_BITS-1:0]   orow_q, ocol_q;
    logic [P_BIT_WIDTH-1:0]  shiftout_q;

    // Beat acceptance and the position/mode of the pixel on the bus (iSof forces origin).
    always_comb begin
        accept_s   = 1'b0;
        row_cur_s  = row_q;
        col_cur_s  = col_q;
        mode_cur_s = mode_q;
        if (bus.clken && ((state_q != ST_IDLE) || bus.iSof)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (bus.iSof) begin
            row_cur_s  = '0;
            col_cur_s  = '0;
            mode_cur_s = bus.iMode;
        end else begin
            row_cur_s  = row_q;
            col_cur_s  = col_q;
            mode_cur_s = mode_q;
        end
    end

    // Next counter values and frame state; row saturates instead of wrapping.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        mode_d  = mode_q;
        state_d = state_q;
        if (accept_s) begin
            mode_d = mode_cur_s;
            if (col_cur_s == LP_COL_LAST) begin
                col_d = '0;
                row_d = (row_cur_s == LP_ROW_MAX) ? row_cur_s : (row_cur_s + LP_ONE);
            end else begin
                col_d = col_cur_s + LP_ONE;
                row_d = row_cur_s;
            end
        end else begin
            mode_d = mode_q;
        end
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_FILL : ST_IDLE;
            ST_FILL, ST_RUN: begin
                if (accept_s) begin
                    if (bus.iSof) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = (row_d >= LP_EDGE) ? ST_RUN : ST_FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame state and position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
        end
    end

    // Line memory read at the current column; line k+1 holds the pixel k+1 rows back.
    always_comb begin
        for (int k = 0; k < P_WIN-1; k++) begin
            line_rd_s[k] = mem_q[k][col_cur_s];
        end
    end

    // Line memories cascade: each read value moves one line older at the same address.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[0][col_cur_s] <= bus.shiftin;
            for (int k = 1; k < P_WIN-1; k++) begin
                mem_q[k][col_cur_s] <= line_rd_s[k-1];
            end
        end
    end

    // Window shift: columns move toward c=0 and the newest column enters at c=P_WIN-1.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < P_WIN; r++) begin
                for (int c = 0; c < P_WIN-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][P_WIN-1] = (r == 0) ? bus.shiftin : line_rd_s[(r == 0) ? 0 : r-1];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Pack the window (w[0][0] in the MSBs), zeroing off-frame cells in pad mode, and qualify it.
    always_comb begin
        grid_d  = '0;
        valid_d = 1'b0;
        for (int r = 0; r < P_WIN; r++) begin
            for (int c = 0; c < P_WIN; c++) begin
                if (mode_cur_s && ((row_cur_s < P_COL_BITS'(r)) ||
                                   (col_cur_s < P_COL_BITS'(P_WIN-1-c)))) begin
                    grid_d[(LP_CELLS-1-(r*P_WIN+c))*P_BIT_WIDTH +: P_BIT_WIDTH] = '0;
                end else begin
                    grid_d[(LP_CELLS-1-(r*P_WIN+c))*P_BIT_WIDTH +: P_BIT_WIDTH] = win_d[r][c];
                end
            end
        end
        if (accept_s) begin
            valid_d = mode_cur_s || ((row_cur_s >= LP_EDGE) && (col_cur_s >= LP_EDGE));
        end else begin
            valid_d = 1'b0;
        end
    end

    // Window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < P_WIN; r++) begin
                for (int c = 0; c < P_WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    // Output registers: updated one cycle after an accepted beat; oValid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q     <= '0;
            valid_q    <= 1'b0;
            orow_q     <= '0;
            ocol_q     <= '0;
            shiftout_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept_s) begin
                grid_q     <= grid_d;
                orow_q     <= row_cur_s;
                ocol_q     <= col_cur_s;
                shiftout_q <= line_rd_s[P_WIN-2];
            end
        end
    end

    assign bus.oGrid    = grid_q;
    assign bus.oValid   = valid_q;
    assign bus.oRow     = orow_q;
    assign bus.oCol     = ocol_q;
    assign bus.shiftout = shiftout_q;
endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer (3x3 window, 8-pixel lines, 8-bit pixels,
// pixel value = row*16+col). Expected outputs are queued when a beat is driven
// and compared when the DUT output register updates.
module tb_window_buffer;
    localparam int BW  = 8;
    localparam int WIN = 3;
    localparam int LW  = 8;
    localparam int CB  = 4;
    localparam int GW  = BW * WIN * WIN;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    window_buffer_if #(.P_BIT_WIDTH(BW), .P_WIN(WIN), .P_COL_BITS(CB)) bus ();

    window_buffer #(
        .P_BIT_WIDTH (BW),
        .P_WIN       (WIN),
        .P_LINE_WIDTH(LW),
        .P_COL_BITS  (CB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic          valid;
        logic [CB-1:0] row;
        logic [CB-1:0] col;
        logic          grid_known;
        logic [GW-1:0] grid;
        logic          so_known;
        logic [BW-1:0] so;
    } exp_t;

    typedef struct {
        logic          sof;
        logic          exp_valid;
        logic [CB-1:0] exp_row;
        logic [CB-1:0] exp_col;
        logic          chk_grid;
        logic [GW-1:0] exp_grid;
    } vec_t;

    exp_t sb_q[$];
    exp_t last_exp;
    vec_t tbl[10];
    int   checks;
    int   errors;
    int   pulse_cnt;
    logic m_active;
    logic m_mode;
    int   m_row;
    int   m_col;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] model_grid(input int R, input int C, input logic mode,
                                                  output logic known);
        logic [GW-1:0] g;
        int pr;
        int pc;
        g     = '0;
        known = 1'b1;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                pr = R - r;
                pc = C - (WIN - 1 - c);
                if (pr >= 0 && pc >= 0) begin
                    g[(WIN*WIN-1-(r*WIN+c))*BW +: BW] = BW'(pr * 16 + pc);
                end else begin
                    g[(WIN*WIN-1-(r*WIN+c))*BW +: BW] = '0;
                    if (!mode) known = 1'b0;
                end
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_mode   = 1'b0;
        m_row    = 0;
        m_col    = 0;
        sb_q.delete();
        last_exp.valid      = 1'b0;
        last_exp.row        = '0;
        last_exp.col        = '0;
        last_exp.grid_known = 1'b1;
        last_exp.grid       = '0;
        last_exp.so_known   = 1'b1;
        last_exp.so         = '0;
    endtask

    // Compare DUT outputs with the oldest queued expectation, or check they held.
    task automatic sample();
        exp_t e;
        if (bus.oValid && bus.oRow == CB'(2)) pulse_cnt++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("valid", GW'(bus.oValid), GW'(e.valid));
            check("row", GW'(bus.oRow), GW'(e.row));
            check("col", GW'(bus.oCol), GW'(e.col));
            if (e.grid_known) check("grid", bus.oGrid, e.grid);
            if (e.so_known) check("shiftout", GW'(bus.shiftout), GW'(e.so));
            last_exp = e;
        end else begin
            check("hold_valid", GW'(bus.oValid), GW'(1'b0));
            check("hold_row", GW'(bus.oRow), GW'(last_exp.row));
            check("hold_col", GW'(bus.oCol), GW'(last_exp.col));
            if (last_exp.grid_known) check("hold_grid", bus.oGrid, last_exp.grid);
            if (last_exp.so_known) check("hold_shiftout", GW'(bus.shiftout), GW'(last_exp.so));
        end
    endtask

    // Drive one clock of stimulus, queue its expectation if accepted, then sample.
    task automatic drive_beat(input logic ce, input logic sof, input logic mode);
        exp_t e;
        int   R;
        int   C;
        logic known;
        logic acc;
        acc = ce && (m_active || sof);
        R = sof ? 0 : m_row;
        C = sof ? 0 : m_col;
        bus.clken   = ce;
        bus.iSof    = sof;
        bus.iMode   = mode;
        bus.shiftin = acc ? BW'(R * 16 + C) : 8'hEE;
        if (acc) begin
            if (sof) m_mode = mode;
            m_active     = 1'b1;
            e.valid      = m_mode || (R >= WIN-1 && C >= WIN-1);
            e.row        = CB'(R);
            e.col        = CB'(C);
            e.grid       = model_grid(R, C, m_mode, known);
            e.grid_known = known;
            e.so_known   = (R >= WIN-1);
            e.so         = BW'((R - (WIN-1)) * 16 + C);
            sb_q.push_back(e);
            if (C + 1 == LW) begin
                m_col = 0;
                m_row = (R == 15) ? R : R + 1;
            end else begin
                m_col = C + 1;
                m_row = R;
            end
        end
        @(posedge clk);
        #1;
        sample();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pulse_cnt = 0;
        bus.clken   = 1'b0;
        bus.iSof    = 1'b0;
        bus.iMode   = 1'b0;
        bus.shiftin = '0;
        rst_n       = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            tbl[i].sof       = (i == 0);
            tbl[i].exp_valid = 1'b1;
            tbl[i].exp_row   = CB'(i / LW);
            tbl[i].exp_col   = CB'(i % LW);
            tbl[i].chk_grid  = 1'b0;
            tbl[i].exp_grid  = '0;
        end
        tbl[0].chk_grid = 1'b1;
        tbl[0].exp_grid = 72'h000000000000000000;
        tbl[9].chk_grid = 1'b1;
        tbl[9].exp_grid = 72'h001011000001000000;

        // Reset state, then beats without iSof are ignored
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'b0, 1'b0);

        // Mode 0, continuous: 24 beats covering rows 0..2
        pulse_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            drive_beat(1'b1, i == 0, 1'b0);
            if (i == 17) check("first_valid_early", GW'(bus.oValid), GW'(1'b0));
            if (i == 18) begin
                check("first_valid", GW'(bus.oValid), GW'(1'b1));
                check("grid_22_literal", bus.oGrid, 72'h202122101112000102);
            end
        end
        check("row2_pulses", GW'(pulse_cnt), GW'(6));

        // Mode 1, table-driven: zero-padded windows from the frame origin
        for (int i = 0; i < 10; i++) begin
            drive_beat(1'b1, tbl[i].sof, 1'b1);
            check("tbl_valid", GW'(bus.oValid), GW'(tbl[i].exp_valid));
            check("tbl_row", GW'(bus.oRow), GW'(tbl[i].exp_row));
            check("tbl_col", GW'(bus.oCol), GW'(tbl[i].exp_col));
            if (tbl[i].chk_grid) check("tbl_grid", bus.oGrid, tbl[i].exp_grid);
        end

        // Mode 0 with clken every other cycle over 3 lines
        for (int i = 0; i < 24; i++) begin
            drive_beat(1'b1, i == 0, 1'b0);
            drive_beat(1'b0, 1'b0, 1'b0);
        end

        // Mid-line iSof at (2,5): restart at the origin
        for (int i = 0; i < 21; i++) drive_beat(1'b1, i == 0, 1'b0);
        drive_beat(1'b1, 1'b1, 1'b0);
        check("restart_row", GW'(bus.oRow), GW'(0));
        check("restart_col", GW'(bus.oCol), GW'(0));
        check("restart_valid", GW'(bus.oValid), GW'(1'b0));
        for (int i = 0; i < 18; i++) drive_beat(1'b1, 1'b0, 1'b0);
        check("restart_first_valid", GW'(bus.oValid), GW'(1'b1));

        // Asynchronous reset after pixel (2,4), then ignored beats until iSof
        for (int i = 0; i < 21; i++) drive_beat(1'b1, i == 0, 1'b0);
        check("pre_reset_valid", GW'(bus.oValid), GW'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sample();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'b0, 1'b0);
        drive_beat(1'b1, 1'b1, 1'b0);
        check("post_reset_sof_col", GW'(bus.oCol), GW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
